bind_direct_mapper: RTL and testbench



---
 rtl/bind_direct_mapper.sv | 194 +++++++++++++++++++
 tb/tb_bind_direct_mapper.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bind_direct_mapper.sv
// bind_direct_mapper: address sequencer for hypervector binding.
// For each element word i it reads A[i] and B[i] from a single-port RAM
// view, streams the pair through the element-multiplication kernel
// (first word = A, last word = B), and writes the kernel result to C[i].
// Optional simulation checks are compiled in when BIND_MAPPER_SVA_EN is
// defined; the synthesized logic is the same either way.
module bind_direct_mapper #(
  parameter int HV_DATA_WIDTH          = 32,
  parameter int HV_ADDRESS_WIDTH       = 5,
  parameter int MAX_HYPERVECTOR_LENGTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        valid,
  input  logic [HV_ADDRESS_WIDTH-1:0] hva,
  input  logic [HV_ADDRESS_WIDTH-1:0] hvb,
  input  logic [HV_ADDRESS_WIDTH-1:0] hvc,
  input  logic [HV_ADDRESS_WIDTH-1:0] hv_offset,
  output logic                        we_n,
  output logic [HV_ADDRESS_WIDTH-1:0] address,
  output logic [HV_DATA_WIDTH-1:0]    data_wr,
  input  logic [HV_DATA_WIDTH-1:0]    data_rd,
  output logic                        done,
  output logic                        k_valid,
  output logic                        k_first,
  output logic                        k_last,
  output logic [HV_DATA_WIDTH-1:0]    k_data_in,
  input  logic [HV_DATA_WIDTH-1:0]    k_data_out,
  input  logic                        k_ready,
  input  logic                        k_done
);

  localparam int AW    = HV_ADDRESS_WIDTH;
  localparam int DW    = HV_DATA_WIDTH;
  localparam int IDX_W = (MAX_HYPERVECTOR_LENGTH > 1) ? $clog2(MAX_HYPERVECTOR_LENGTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_HYPERVECTOR_LENGTH - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD_A   = 4'd1;
  localparam logic [3:0] S_RD_B   = 4'd2;
  localparam logic [3:0] S_CAP_B  = 4'd3;
  localparam logic [3:0] S_SEND_A = 4'd4;
  localparam logic [3:0] S_SEND_B = 4'd5;
  localparam logic [3:0] S_WAIT_K = 4'd6;
  localparam logic [3:0] S_WRITE  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  // Base addresses are stored with the offset already folded in, so each
  // access only needs one add of the element index (wrapping naturally).
  logic [AW-1:0]    a_base_q, a_base_d;
  logic [AW-1:0]    b_base_q, b_base_d;
  logic [AW-1:0]    c_base_q, c_base_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [DW-1:0]    r_q, r_d;

  // Next-state and datapath capture decisions
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          i_d      = '0;
          a_base_d = hva + hv_offset;
          b_base_d = hvb + hv_offset;
          c_base_d = hvc + hv_offset;
          state_d  = S_RD_A;
        end
      end
      S_RD_A:   state_d = S_RD_B;
      S_RD_B: begin
        a_d     = data_rd;
        state_d = S_CAP_B;
      end
      S_CAP_B: begin
        b_d     = data_rd;
        state_d = S_SEND_A;
      end
      S_SEND_A: if (k_ready) state_d = S_SEND_B;
      S_SEND_B: if (k_ready) state_d = S_WAIT_K;
      S_WAIT_K: begin
        if (k_done) begin
          r_d     = k_data_out;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_RD_A;
        end
      end
      S_DONE:   if (!valid) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
    end
  end

  // Outputs decoded purely from registered state; idle values everywhere else
  always_comb begin
    we_n      = 1'b1;
    address   = '0;
    data_wr   = '0;
    done      = 1'b0;
    k_valid   = 1'b0;
    k_first   = 1'b0;
    k_last    = 1'b0;
    k_data_in = '0;
    case (state_q)
      S_RD_A: address = a_base_q + AW'(i_q);
      S_RD_B: address = b_base_q + AW'(i_q);
      S_SEND_A: begin
        k_valid   = 1'b1;
        k_first   = 1'b1;
        k_data_in = a_q;
      end
      S_SEND_B: begin
        k_valid   = 1'b1;
        k_last    = 1'b1;
        k_data_in = b_q;
      end
      S_WRITE: begin
        we_n    = 1'b0;
        address = c_base_q + AW'(i_q);
        data_wr = r_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef BIND_MAPPER_SVA_EN
  // True when the L-word window starting at x partially overlaps the one at
  // y (modulo the address space); identical windows are not flagged.
  function automatic logic ranges_overlap(input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] d;
    int unsigned   fwd;
    int unsigned   bwd;
    d   = x - y;
    fwd = int'(d);
    bwd = (1 << AW) - fwd;
    return (fwd != 0) && ((fwd < MAX_HYPERVECTOR_LENGTH) || (bwd < MAX_HYPERVECTOR_LENGTH));
  endfunction

  a_first_last_excl: assert property (@(posedge clk) disable iff (!reset_n) !(k_first && k_last))
    else $error("k_first and k_last asserted together");
  a_write_only_in_write: assert property (@(posedge clk) disable iff (!reset_n) !we_n |-> (state_q == S_WRITE))
    else $error("we_n low outside WRITE");
  a_done_no_write: assert property (@(posedge clk) disable iff (!reset_n) done |-> we_n)
    else $error("done high while writing");

  // Flag partially overlapping result windows at the moment a command starts
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == S_IDLE) && valid) begin
      if (ranges_overlap(hvc, hva) || ranges_overlap(hvc, hvb))
        $warning("result window partially overlaps an operand window");
    end
  end
`endif

endmodule

// File: tb/tb_bind_direct_mapper.sv
// Self-checking bench for bind_direct_mapper: bench-side synchronous RAM,
// XOR kernel, and a word-level reference model of the binding operation.
module tb_bind_direct_mapper;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int L     = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid;
  logic [AW-1:0] hva, hvb, hvc, hv_offset;
  logic          we_n;
  logic [AW-1:0] address;
  logic [DW-1:0] data_wr;
  logic [DW-1:0] data_rd;
  logic          done;
  logic          k_valid, k_first, k_last;
  logic [DW-1:0] k_data_in;
  logic [DW-1:0] k_data_out;
  logic          k_ready;
  logic          k_done;

  always #5 clk = ~clk;

  bind_direct_mapper #(
    .HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW), .MAX_HYPERVECTOR_LENGTH(L)
  ) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid),
    .hva(hva), .hvb(hvb), .hvc(hvc), .hv_offset(hv_offset),
    .we_n(we_n), .address(address), .data_wr(data_wr), .data_rd(data_rd),
    .done(done), .k_valid(k_valid), .k_first(k_first), .k_last(k_last),
    .k_data_in(k_data_in), .k_data_out(k_data_out), .k_ready(k_ready), .k_done(k_done)
  );

  // RAM with one-cycle read latency, plus a bench-side load port
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  assign data_rd = rd_q;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (!we_n) mem[address] <= data_wr;
    rd_q <= mem[address];
  end

  // XOR kernel: result available the cycle after the last word is accepted
  logic [DW-1:0] ka_q;
  always @(posedge clk) begin
    if (!reset_n) begin
      k_done     <= 1'b0;
      k_data_out <= '0;
      ka_q       <= '0;
    end else begin
      k_done <= 1'b0;
      if (k_valid && k_ready && k_first) ka_q <= k_data_in;
      if (k_valid && k_ready && k_last) begin
        k_done     <= 1'b1;
        k_data_out <= ka_q ^ k_data_in;
      end
    end
  end

  // Reference model state
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [AW+DW-1:0] exp_wr_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Element-by-element binding: C[i] = A[i] ^ B[i], reads before the write
  task automatic model_bind(input int a, input int b, input int c, input int off, input int n);
    for (int i = 0; i < n; i++) begin
      int ia, ib, ic;
      logic [DW-1:0] r;
      ia = (a + off + i) % DEPTH;
      ib = (b + off + i) % DEPTH;
      ic = (c + off + i) % DEPTH;
      r = ref_mem[ia] ^ ref_mem[ib];
      ref_mem[ic] = r;
      exp_wr_q.push_back({AW'(ic), r});
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = ref_mem[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check_eq($sformatf("%s_mem[%0d]", tag, i), mem[i], ref_mem[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_we_n"}, we_n, 1);
    check_eq({tag, "_address"}, address, 0);
    check_eq({tag, "_data_wr"}, data_wr, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_kstrobes"}, {k_valid, k_first, k_last}, 0);
    check_eq({tag, "_k_data_in"}, k_data_in, 0);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int c, input int off,
                        input int stall_elem, input int stall_n, input bit rand_ready,
                        input int hold_cycles, input bit drop_mid);
    int cycles, stalls, firsts, budget, e, ph;
    bit prev_stall, finished;
    logic snap_kv, snap_kf, snap_kl;
    logic [DW-1:0] snap_d;
    logic [AW+DW-1:0] got_wr [$];
    exp_wr_q.delete();
    model_bind(a, b, c, off, L);
    @(negedge clk);
    hva = AW'(a); hvb = AW'(b); hvc = AW'(c); hv_offset = AW'(off);
    valid = 1'b1; k_ready = 1'b1;
    cycles = 0; stalls = 0; firsts = 0; budget = stall_n;
    prev_stall = 1'b0; finished = 1'b0;
    snap_kv = 1'b0; snap_kf = 1'b0; snap_kl = 1'b0; snap_d = '0;
    while (!finished && cycles < 1000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (drop_mid && cycles == 10) valid = 1'b0;
      if (prev_stall) begin
        check_eq({tag, "_stall_kvalid"}, k_valid, snap_kv);
        check_eq({tag, "_stall_kfirst"}, k_first, snap_kf);
        check_eq({tag, "_stall_klast"}, k_last, snap_kl);
        check_eq({tag, "_stall_kdata"}, k_data_in, snap_d);
      end
      if (k_valid) check_eq({tag, "_one_strobe"}, k_first ^ k_last, 1);
      else check_eq({tag, "_no_strobe"}, {k_first, k_last}, 0);
      if (!we_n) got_wr.push_back({address, data_wr});
      if (done) begin
        check_eq({tag, "_done_we_n"}, we_n, 1);
        finished = 1'b1;
      end else begin
        if (stall_n == 0 && !rand_ready && cycles <= 7 * L) begin
          e  = (cycles - 1) / 7;
          ph = (cycles - 1) % 7;
          if (ph == 0) check_eq($sformatf("%s_rdA%0d", tag, e), {we_n, address}, {1'b1, AW'((a + off + e) % DEPTH)});
          else if (ph == 1) check_eq($sformatf("%s_rdB%0d", tag, e), {we_n, address}, {1'b1, AW'((b + off + e) % DEPTH)});
          else if (ph == 6) check_eq($sformatf("%s_wrC%0d", tag, e), {we_n, address}, {1'b0, AW'((c + off + e) % DEPTH)});
          else check_eq($sformatf("%s_nowr%0d_%0d", tag, e, ph), we_n, 1);
        end
        if (k_valid && k_first && firsts == stall_elem && budget > 0) begin
          k_ready = 1'b0;
          budget--;
        end else if (rand_ready) begin
          k_ready = ($urandom_range(0, 3) != 0);
        end else begin
          k_ready = 1'b1;
        end
        if (k_valid && k_ready && k_first) firsts++;
        prev_stall = k_valid && !k_ready;
        if (prev_stall) stalls++;
        snap_kv = k_valid; snap_kf = k_first; snap_kl = k_last; snap_d = k_data_in;
      end
    end
    k_ready = 1'b1;
    check_eq({tag, "_done_seen"}, finished, 1);
    check_eq({tag, "_latency"}, cycles, 7 * L + 1 + stalls);
    check_eq({tag, "_wr_count"}, got_wr.size(), exp_wr_q.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr_q.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr_q[i]);
    if (!drop_mid) begin
      for (int h = 0; h < hold_cycles; h++) begin
        @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("%s_hold%0d", tag, h), {done, we_n, k_valid}, 3'b110);
      end
    end
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_idle_done"}, done, 0);
    check_eq({tag, "_idle_we_n"}, we_n, 1);
    compare_mem(tag);
  endtask

  initial begin
    int lasts, cycles;
    logic [DW-1:0] expect_ab [L];
    reset_n = 1'b0; valid = 1'b0;
    hva = '0; hvb = '0; hvc = '0; hv_offset = '0;
    k_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Basic bind with the fixed patterns, then hold valid after done
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < L; i++) begin
      ref_mem[i]     = 32'hF0F0F0F0;
      ref_mem[4 + i] = 32'hFF00FF00;
    end
    load_all();
    run_op("basic", 0, 4, 8, 0, -1, 0, 1'b0, 6, 1'b0);
    for (int i = 0; i < L; i++)
      check_eq($sformatf("basic_C%0d", i), mem[8 + i], 32'h0FF00FF0);

    // Offset pushes addresses past the top of memory
    randomize_mem();
    load_all();
    run_op("wrap", 28, 8, 29, 3, -1, 0, 1'b0, 1, 1'b0);

    // Five stalled cycles in SEND_A of element 0
    randomize_mem();
    load_all();
    run_op("bp", 2, 12, 20, 0, 0, 5, 1'b0, 0, 1'b0);

    // In-place: result overwrites A
    randomize_mem();
    load_all();
    for (int i = 0; i < L; i++) expect_ab[i] = ref_mem[i] ^ ref_mem[4 + i];
    run_op("inplace", 0, 4, 0, 0, -1, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < L; i++)
      check_eq($sformatf("inplace_C%0d", i), mem[i], expect_ab[i]);

    // Random commands with random kernel backpressure
    for (int t = 0; t < 6; t++) begin
      randomize_mem();
      load_all();
      run_op($sformatf("rand%0d", t), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
             $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), -1, 0, 1'b1,
             $urandom_range(0, 4), 1'(($urandom_range(0, 1))));
    end

    // Reset in WAIT_K of element 2: only C[0..1] may be written
    randomize_mem();
    load_all();
    exp_wr_q.delete();
    model_bind(16, 20, 24, 1, 2);
    @(negedge clk);
    hva = 5'd16; hvb = 5'd20; hvc = 5'd24; hv_offset = 5'd1;
    valid = 1'b1; k_ready = 1'b1;
    lasts = 0; cycles = 0;
    while (lasts < 3 && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (k_valid && k_last && k_ready) lasts++;
    end
    check_eq("rst_reach_elem2", lasts, 3);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    valid   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    reset_n = 1'b1;
    for (int h = 0; h < 10; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("midrst_quiet%0d", h), {we_n, done}, 2'b10);
    end
    compare_mem("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
